// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between the PC register, instruction memory and decode.
// Fetches one word at a time over imem_req/imem_ack, presents it to decode with an
// inst_valid/stall handshake, then pulses pc_en for one clock with a branch select and
// target so the PC register either advances (PC+4) or loads a redirect.
//
// Optional build macro: FETCH_TIMEOUT_EN adds a REQ watchdog (TIMEOUT_CYC parameter).
// On timeout, fetch_err pulses, imem_req drops for one clock, and the same address is
// requested again. Without the macro, REQ waits forever and fetch_err is tied low.
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   pc_in                        current PC from the PC register
//   pc_en, br_en_o, br_addr_o    registered PC update pulse, branch select and target
//   branch_en, branch_addr       redirect request from execute (1-clk pulse)
//   imem_req, imem_addr          memory request and address, held until imem_ack
//   imem_ack, imem_rdata         memory completion and word
//   inst_valid, inst, inst_pc    instruction presented to decode
//   stall                        decode back-pressure
//   fetch_err                    1-clk pulse on memory timeout
module fetch_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_en,
  output logic              br_en_o,
  output logic [ADDR_W-1:0] br_addr_o,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              stall,
  output logic              fetch_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [2:0] S_RETRY  = 3'd5;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYC + 1);
`endif

  logic [2:0]        state, state_d;
  logic              pend_br, pend_br_d;
  logic [ADDR_W-1:0] pend_addr, pend_addr_d;
  logic              pc_en_d, br_en_d;
  logic [ADDR_W-1:0] br_addr_d;
  logic              imem_req_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic              inst_valid_d;
  logic [DATA_W-1:0] inst_d;
  logic [ADDR_W-1:0] inst_pc_d;
  logic              kill_c;
  logic [ADDR_W-1:0] tgt_c;
`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc_c;
  logic              fetch_err_d;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    pend_br_d    = pend_br;
    pend_addr_d  = pend_addr;
    pc_en_d      = 1'b0;
    br_en_d      = 1'b0;
    br_addr_d    = '0;
    imem_req_d   = imem_req;
    imem_addr_d  = imem_addr;
    inst_valid_d = inst_valid;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
`ifdef FETCH_TIMEOUT_EN
    cnt_d        = cnt;
    cnt_inc_c    = cnt + CNT_W'(1);
    fetch_err_d  = 1'b0;
`endif

    // A redirect arriving this cycle counts as pending, so the word it kills is never issued.
    kill_c = pend_br | branch_en;
    tgt_c  = branch_en ? branch_addr : pend_addr;

    // Capture redirects; the newest one wins.
    if (branch_en && (state != S_IDLE)) begin
      pend_br_d   = 1'b1;
      pend_addr_d = branch_addr;
    end

    case (state)
      S_IDLE: begin
        state_d     = S_REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_in;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      S_REQ: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          if (kill_c) begin
            state_d   = S_UPDATE;
            pc_en_d   = 1'b1;
            br_en_d   = 1'b1;
            br_addr_d = tgt_c;
          end else begin
            state_d      = S_ISSUE;
            inst_valid_d = 1'b1;
            inst_d       = imem_rdata;
            inst_pc_d    = imem_addr;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_inc_c == CNT_W'(TIMEOUT_CYC)) begin
          state_d     = S_RETRY;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
`endif
      end
      S_ISSUE: begin
        // Leave on a transfer, or on a redirect that kills the word.
        if (branch_en || !stall) begin
          state_d      = S_UPDATE;
          inst_valid_d = 1'b0;
          pc_en_d      = 1'b1;
          br_en_d      = kill_c;
          br_addr_d    = kill_c ? tgt_c : '0;
        end
      end
      S_UPDATE: begin
        // pc_en drops by default; a redirect arriving now waits for the next update.
        state_d = S_SETTLE;
        if (!branch_en) begin
          pend_br_d = 1'b0;
        end
      end
      S_SETTLE: begin
        state_d     = S_REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_in;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      S_RETRY: begin
        // Re-request the same address after one clock with imem_req low.
        state_d    = S_REQ;
        imem_req_d = 1'b1;
        cnt_d      = '0;
      end
`endif
      default: begin
        state_d      = S_IDLE;
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pend_br    <= 1'b0;
      pend_addr  <= '0;
      pc_en      <= 1'b0;
      br_en_o    <= 1'b0;
      br_addr_o  <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_d;
      pend_br    <= pend_br_d;
      pend_addr  <= pend_addr_d;
      pc_en      <= pc_en_d;
      br_en_o    <= br_en_d;
      br_addr_o  <= br_addr_d;
      imem_req   <= imem_req_d;
      imem_addr  <= imem_addr_d;
      inst_valid <= inst_valid_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog counter and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      fetch_err <= fetch_err_d;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule
